// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the requester handshakes, the buffer-side strobes/address/data and
// the occupancy status of mem_arbiter into one interface.
//
//   wr_req / wr_data / wr_gnt      write requester (element loader)
//   rd_req / rd_gnt                read requester (multiply datapath)
//   rd_valid / rd_data             read return, one cycle after rd_gnt
//   mem_wen / mem_ren / mem_addr   single-port buffer strobes and address
//   mem_wdata / mem_rdata          buffer write data / synchronous read data
//   count / full / empty           FIFO occupancy status
//
// Modports:
//   slave  - the arbiter: consumes requests and mem_rdata, drives the rest.
//   master - the surrounding logic: requesters plus the buffer read data.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int WIDTH = 136,
  parameter int PTR_W = 6
);
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             wr_gnt;
  logic             rd_req;
  logic             rd_gnt;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             mem_wen;
  logic             mem_ren;
  logic [PTR_W-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;

  modport slave (
    input  wr_req, wr_data, rd_req, mem_rdata,
    output wr_gnt, rd_gnt, rd_valid, rd_data,
           mem_wen, mem_ren, mem_addr, mem_wdata,
           count, full, empty
  );

  modport master (
    output wr_req, wr_data, rd_req, mem_rdata,
    input  wr_gnt, rd_gnt, rd_valid, rd_data,
           mem_wen, mem_ren, mem_addr, mem_wdata,
           count, full, empty
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Single-port access scheduler for the matrix-element buffer. The buffer is
// run as a circular FIFO shared by one writer and one reader; at most one
// access is granted per cycle, round-robin under contention.
//
// Ports:
//   clk    - sole clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - mem_arbiter_if.slave (requests, grants, buffer lines, status)
//
// Grants are combinational from the current requests and registered state;
// the access commits on the rising edge that ends the grant cycle. Read data
// comes straight from the buffer's synchronous output, qualified by a
// registered rd_valid.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ENTRIES = 64,
  parameter int WIDTH   = 136,
  parameter int PTR_W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [PTR_W:0]   FULL_CNT_C = (PTR_W+1)'(ENTRIES);
  localparam logic [PTR_W:0]   ZERO_CNT_C = (PTR_W+1)'(0);
  localparam logic [PTR_W:0]   CNT_ONE_C  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO_C = PTR_W'(0);

  // Registered state
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             prio_r;      // 0: writer favoured, 1: reader favoured
  logic             rd_valid_r;

  // Combinational decode
  logic             full_s;
  logic             empty_s;
  logic             w_ok_s;
  logic             r_ok_s;
  logic             wr_gnt_s;
  logic             rd_gnt_s;
  logic [PTR_W-1:0] addr_s;

  assign full_s  = (count_r == FULL_CNT_C);
  assign empty_s = (count_r == ZERO_CNT_C);

  // A full buffer cannot take a write and an empty one cannot serve a read,
  // so the other side wins a contested cycle regardless of prio.
  assign w_ok_s = bus.wr_req & ~full_s;
  assign r_ok_s = bus.rd_req & ~empty_s;

  // One-hot-or-zero grant selection; grants are suppressed while in reset.
  always_comb begin
    wr_gnt_s = 1'b0;
    rd_gnt_s = 1'b0;
    if (reset) begin
      wr_gnt_s = 1'b0;
      rd_gnt_s = 1'b0;
    end else if (w_ok_s && r_ok_s) begin
      if (prio_r) begin
        rd_gnt_s = 1'b1;
      end else begin
        wr_gnt_s = 1'b1;
      end
    end else if (w_ok_s) begin
      wr_gnt_s = 1'b1;
    end else if (r_ok_s) begin
      rd_gnt_s = 1'b1;
    end else begin
      wr_gnt_s = 1'b0;
      rd_gnt_s = 1'b0;
    end
  end

  // Buffer address: write pointer on a write strobe, read pointer otherwise.
  always_comb begin
    addr_s = rd_ptr_r;
    if (wr_gnt_s) begin
      addr_s = wr_ptr_r;
    end else begin
      addr_s = rd_ptr_r;
    end
  end

  // Commit the granted access. Whoever is granted, prio then points at the
  // other side: in a contested cycle that is the loser, in an uncontested one
  // it is the side not served. Pointers wrap naturally as ENTRIES == 2**PTR_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= PTR_ZERO_C;
      rd_ptr_r   <= PTR_ZERO_C;
      count_r    <= ZERO_CNT_C;
      prio_r     <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_gnt_s;
      case ({wr_gnt_s, rd_gnt_s})
        2'b10: begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
          count_r  <= count_r + CNT_ONE_C;
          prio_r   <= 1'b1;
        end
        2'b01: begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
          count_r  <= count_r - CNT_ONE_C;
          prio_r   <= 1'b0;
        end
        default: begin
          wr_ptr_r <= wr_ptr_r;
          rd_ptr_r <= rd_ptr_r;
          count_r  <= count_r;
          prio_r   <= prio_r;
        end
      endcase
    end
  end

  assign bus.wr_gnt    = wr_gnt_s;
  assign bus.rd_gnt    = rd_gnt_s;
  assign bus.mem_wen   = wr_gnt_s;
  assign bus.mem_ren   = rd_gnt_s;
  assign bus.mem_addr  = addr_s;
  assign bus.mem_wdata = bus.wr_data;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_data   = bus.mem_rdata;
  assign bus.count     = count_r;
  assign bus.full      = full_s;
  assign bus.empty     = empty_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed and randomized checks of mem_arbiter against a queue-based model
// of the FIFO plus a round-robin "who is favoured" bit. The bench also holds
// the single-port buffer itself (synchronous read, one-cycle latency).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int ENTRIES = 64;
  localparam int WIDTH   = 136;
  localparam int PTR_W   = 6;

  logic clk = 1'b0;
  logic reset;

  mem_arbiter_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) bus ();

  mem_arbiter #(.ENTRIES(ENTRIES), .WIDTH(WIDTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Buffer model: single port, synchronous read.
  logic [WIDTH-1:0] mem [ENTRIES];
  always @(posedge clk) begin
    if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Reference model state
  logic [WIDTH-1:0] q[$];
  int  wr_total;
  int  rd_total;
  bit  fav_rd;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string tag, logic [159:0] obs, logic [159:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endfunction

  function automatic logic [WIDTH-1:0] rnd();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[WIDTH-1:0];
  endfunction

  task automatic model_clear();
    q.delete();
    wr_total = 0;
    rd_total = 0;
    fav_rd   = 1'b0;
  endtask

  // Apply reset for one edge, check reset values, release at posedge+1.
  task automatic do_reset();
    reset       = 1'b1;
    bus.wr_req  = 1'b1;   // a request during reset must not be granted
    bus.rd_req  = 1'b1;
    bus.wr_data = '0;
    #1;
    chk("rst_wr_gnt",  160'(bus.wr_gnt),   160'(0));
    chk("rst_rd_gnt",  160'(bus.rd_gnt),   160'(0));
    chk("rst_mem_wen", 160'(bus.mem_wen),  160'(0));
    chk("rst_mem_ren", 160'(bus.mem_ren),  160'(0));
    chk("rst_addr",    160'(bus.mem_addr), 160'(0));
    chk("rst_count",   160'(bus.count),    160'(0));
    chk("rst_empty",   160'(bus.empty),    160'(1));
    chk("rst_full",    160'(bus.full),     160'(0));
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rd_valid", 160'(bus.rd_valid), 160'(0));
    reset = 1'b0;
    model_clear();
  endtask

  // One cycle: drive requests at posedge+1, check grants, commit, check results.
  task automatic cycle(input bit wreq, input logic [WIDTH-1:0] wd, input bit rreq,
                       output bit got_w, output bit got_r);
    bit w_ok, r_ok, ew, er;
    logic [WIDTH-1:0] exp_rd;
    int ea;
    exp_rd = '0;
    bus.wr_req  = wreq;
    bus.wr_data = wd;
    bus.rd_req  = rreq;
    #1;
    w_ok = wreq && (q.size() < ENTRIES);
    r_ok = rreq && (q.size() > 0);
    ew   = w_ok && !(r_ok && fav_rd);
    er   = r_ok && !ew;
    chk("wr_gnt",  160'(bus.wr_gnt),  160'(ew));
    chk("rd_gnt",  160'(bus.rd_gnt),  160'(er));
    chk("mem_wen", 160'(bus.mem_wen), 160'(ew));
    chk("mem_ren", 160'(bus.mem_ren), 160'(er));
    if (ew || er) begin
      ea = ew ? (wr_total % ENTRIES) : (rd_total % ENTRIES);
      chk("mem_addr", 160'(bus.mem_addr), 160'(ea));
    end
    if (ew) chk("mem_wdata", 160'(bus.mem_wdata), 160'(wd));
    if (ew) begin
      q.push_back(wd);
      wr_total++;
      fav_rd = 1'b1;
    end
    if (er) begin
      exp_rd = q.pop_front();
      rd_total++;
      fav_rd = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 160'(bus.rd_valid), 160'(er));
    if (er) chk("rd_data", 160'(bus.rd_data), 160'(exp_rd));
    chk("count", 160'(bus.count), 160'(q.size()));
    chk("full",  160'(bus.full),  160'(q.size() == ENTRIES));
    chk("empty", 160'(bus.empty), 160'(q.size() == 0));
    got_w = ew;
    got_r = er;
  endtask

  initial begin
    bit gw, gr;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] a0;
    reset       = 1'b1;
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_data = '0;
    model_clear();

    // Basic write 3 / read 3
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a0 = WIDTH'(8'hA0 + 8'(i));
      cycle(1'b1, a0, 1'b0, gw, gr);
    end
    chk("three_count", 160'(bus.count), 160'(3));
    chk("three_empty", 160'(bus.empty), 160'(0));
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, gw, gr);
    chk("drain_empty", 160'(bus.empty), 160'(1));

    // Fill, hold the 65th write, free one slot, wrap to address 0
    do_reset();
    for (int i = 0; i < ENTRIES; i++) cycle(1'b1, rnd(), 1'b0, gw, gr);
    chk("fill_full",  160'(bus.full),  160'(1));
    chk("fill_count", 160'(bus.count), 160'(ENTRIES));
    d = rnd();
    cycle(1'b1, d, 1'b0, gw, gr);   // held off
    cycle(1'b1, d, 1'b1, gw, gr);   // read wins while full
    cycle(1'b1, d, 1'b0, gw, gr);   // held write lands at wrapped address 0

    // Contention from count = 10 with writer favoured
    do_reset();
    for (int i = 0; i < 11; i++) cycle(1'b1, rnd(), 1'b0, gw, gr);
    cycle(1'b0, '0, 1'b1, gw, gr);
    for (int i = 0; i < 8; i++) cycle(1'b1, rnd(), 1'b1, gw, gr);
    chk("contend_count", 160'(bus.count), 160'(10));

    // Empty contention: write first, then the read returns it
    for (int i = 0; i < ENTRIES && q.size() > 0; i++) cycle(1'b0, '0, 1'b1, gw, gr);
    d = rnd();
    cycle(1'b1, d, 1'b1, gw, gr);
    cycle(1'b0, '0, 1'b1, gw, gr);

    // Wrap-around: 100 interleaved pairs
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, rnd(), 1'b0, gw, gr);
      cycle(1'b0, '0, 1'b1, gw, gr);
    end

    // Randomized traffic with varying request densities
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = (i < 200) ? 70 : ((i < 400) ? 30 : 50);
      cycle($urandom_range(0, 99) < wp, rnd(), $urandom_range(0, 99) < 50, gw, gr);
    end

    // Reset in the cycle after a read grant
    do_reset();
    cycle(1'b1, rnd(), 1'b0, gw, gr);
    cycle(1'b1, rnd(), 1'b0, gw, gr);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1;
    #1;
    chk("pre_rst_rd_gnt", 160'(bus.rd_gnt), 160'(1));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_rd_valid", 160'(bus.rd_valid), 160'(0));
    chk("mid_rst_count",    160'(bus.count),    160'(0));
    chk("mid_rst_empty",    160'(bus.empty),    160'(1));
    chk("mid_rst_addr",     160'(bus.mem_addr), 160'(0));
    bus.rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_rd_valid", 160'(bus.rd_valid), 160'(0));
    end
    reset = 1'b0;
    model_clear();

    // Reset asserted while a read grant is pending: the read never commits
    cycle(1'b1, rnd(), 1'b0, gw, gr);
    bus.rd_req = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("rst_gnt_drop", 160'(bus.rd_gnt), 160'(0));
    @(posedge clk);
    #1;
    chk("rst_gnt_valid", 160'(bus.rd_valid), 160'(0));
    chk("rst_gnt_count", 160'(bus.count),    160'(0));
    bus.rd_req = 1'b0;
    reset = 1'b0;
    model_clear();

    // Normal operation after reset, starting at address 0
    d = rnd();
    cycle(1'b1, d, 1'b0, gw, gr);
    cycle(1'b0, '0, 1'b1, gw, gr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
